// File: rtl/vga_timing.sv
// Raster timing generator: divides CLK to the pixel rate, runs the h/v counters
// and drives registered sync, coordinate, blank and per-frame strobe outputs.
module vga_timing #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   output logic       HS,
   output logic       VS,
   output logic       HS_probe,
   output logic       VS_probe,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       blank,
   output logic       pix_en,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div;
   logic [9:0]       h;
   logic [9:0]       v;
   logic             tick;
   logic             tick_q;
   logic             hs_act;
   logic             vs_act;

   // With CLK_DIV == 1 the divider is stuck at 0 and DIV_LAST is 0, so tick is constant 1.
   assign tick   = (div == DIV_LAST);
   assign hs_act = (h >= HS_START) && (h < HS_END);
   assign vs_act = (v >= VS_START) && (v < VS_END);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div    <= '0;
         h      <= '0;
         v      <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick;
         if (tick) begin
            div <= '0;
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
               h <= h + 10'd1;
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   // tick_q marks that h/v changed on the previous edge, so pix_en and frame_start
   // line up with the cycle in which x/y first show the new position.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         x           <= '0;
         y           <= '0;
         blank       <= 1'b0;
         HS          <= ~SYNC_POL;
         VS          <= ~SYNC_POL;
         HS_probe    <= ~SYNC_POL;
         VS_probe    <= ~SYNC_POL;
         pix_en      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         x           <= h;
         y           <= v;
         blank       <= (h >= H_VIS) | (v >= V_VIS);
         HS          <= hs_act ? SYNC_POL : ~SYNC_POL;
         VS          <= vs_act ? SYNC_POL : ~SYNC_POL;
         HS_probe    <= hs_act ? SYNC_POL : ~SYNC_POL;
         VS_probe    <= vs_act ? SYNC_POL : ~SYNC_POL;
         pix_en      <= tick_q;
         frame_start <= tick_q && (h == 10'd0) && (v == 10'd0);
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: two small-raster instances (divide-by-4 active-low,
// divide-by-1 active-high) checked every cycle against an arithmetic pixel-count model.
module tb_vga_timing;

   localparam int HV = 20, HF = 4, HSW = 6, HB = 5;
   localparam int VV = 12, VF = 2, VSW = 3, VB = 4;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;

   typedef struct {
      int   x;
      int   y;
      logic blank;
      logic hs;
      logic vs;
      logic pix_en;
      logic fs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       a_hs, a_vs, a_hsp, a_vsp, a_blank, a_pe, a_fs;
   logic       b_hs, b_vs, b_hsp, b_vsp, b_blank, b_pe, b_fs;
   logic [9:0] a_x, a_y, b_x, b_y;

   int checks   = 0;
   int failures = 0;
   int n_edges;
   int max_ay   = 0;
   bit cmp_on   = 1'b0;

   always #5 clk = ~clk;

   vga_timing #(.CLK_DIV(4), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .SYNC_POL(1'b0))
   dut_a (.CLK(clk), .RST(rst), .HS(a_hs), .VS(a_vs), .HS_probe(a_hsp), .VS_probe(a_vsp),
          .x(a_x), .y(a_y), .blank(a_blank), .pix_en(a_pe), .frame_start(a_fs));

   vga_timing #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .SYNC_POL(1'b1))
   dut_b (.CLK(clk), .RST(rst), .HS(b_hs), .VS(b_vs), .HS_probe(b_hsp), .VS_probe(b_vsp),
          .x(b_x), .y(b_y), .blank(b_blank), .pix_en(b_pe), .frame_start(b_fs));

   // Clock edges seen since reset last released; the whole model is derived from this count.
   always @(posedge clk or posedge rst) begin
      if (rst) n_edges <= 0;
      else     n_edges <= n_edges + 1;
   end

   // Pixel count after n edges is n/d; outputs show the count from one edge earlier.
   function automatic exp_t model(input int n, input int d, input bit pol);
      exp_t e;
      int p, hh, vv;
      e.x = 0; e.y = 0; e.blank = 1'b0; e.hs = ~pol; e.vs = ~pol;
      e.pix_en = 1'b0; e.fs = 1'b0;
      if (n >= 1) begin
         p  = (n - 1) / d;
         hh = p % HT;
         vv = (p / HT) % VT;
         e.x      = hh;
         e.y      = vv;
         e.blank  = (hh >= HV) || (vv >= VV);
         e.hs     = (hh >= HV + HF && hh < HV + HF + HSW) ? pol : ~pol;
         e.vs     = (vv >= VV + VF && vv < VV + VF + VSW) ? pol : ~pol;
         e.pix_en = (n >= 2) && ((n - 1) % d == 0);
         e.fs     = e.pix_en && (p % (HT * VT) == 0);
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t ea, eb;
      if (cmp_on) begin
         ea = model(n_edges, 4, 1'b0);
         eb = model(n_edges, 1, 1'b1);
         checkOutput("a_x", 32'(a_x), 32'(ea.x));
         checkOutput("a_y", 32'(a_y), 32'(ea.y));
         checkOutput("a_blank", 32'(a_blank), 32'(ea.blank));
         checkOutput("a_hs", 32'(a_hs), 32'(ea.hs));
         checkOutput("a_vs", 32'(a_vs), 32'(ea.vs));
         checkOutput("a_hs_probe", 32'(a_hsp), 32'(ea.hs));
         checkOutput("a_vs_probe", 32'(a_vsp), 32'(ea.vs));
         checkOutput("a_pix_en", 32'(a_pe), 32'(ea.pix_en));
         checkOutput("a_frame_start", 32'(a_fs), 32'(ea.fs));
         checkOutput("b_x", 32'(b_x), 32'(eb.x));
         checkOutput("b_y", 32'(b_y), 32'(eb.y));
         checkOutput("b_blank", 32'(b_blank), 32'(eb.blank));
         checkOutput("b_hs", 32'(b_hs), 32'(eb.hs));
         checkOutput("b_vs", 32'(b_vs), 32'(eb.vs));
         checkOutput("b_hs_probe", 32'(b_hsp), 32'(eb.hs));
         checkOutput("b_vs_probe", 32'(b_vsp), 32'(eb.vs));
         checkOutput("b_pix_en", 32'(b_pe), 32'(eb.pix_en));
         checkOutput("b_frame_start", 32'(b_fs), 32'(eb.fs));
         if (32'(a_y) > max_ay) max_ay = 32'(a_y);
      end
   end

   function automatic logic sigOf(input int sel);
      case (sel)
         0: return a_hs;
         1: return b_hs;
         2: return a_fs;
         default: return b_fs;
      endcase
   endfunction

   // Counts CLKs of the active phase and the full period of a level signal (sampled #1 after posedge).
   task automatic measurePulse(input string name, input int sel, input logic act_lvl,
                               input int exp_width, input int exp_period);
      int cnt, width, period;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (sigOf(sel) != act_lvl) begin ok = 1'b1; break; end
      end
      for (int i = 0; ok && i < 4000; i++) begin
         @(posedge clk); #1;
         if (sigOf(sel) == act_lvl) break;
         if (i == 3999) ok = 1'b0;
      end
      cnt = 1; width = 0; period = 0;
      for (int i = 0; ok && i < 4000; i++) begin
         @(posedge clk); #1;
         if (width == 0 && sigOf(sel) != act_lvl) width = cnt;
         if (width != 0 && sigOf(sel) == act_lvl) begin period = cnt; break; end
         cnt++;
      end
      checkOutput({name, "_width"}, 32'(width), 32'(exp_width));
      checkOutput({name, "_period"}, 32'(period), 32'(exp_period));
   endtask

   task automatic measureFrame(input string name, input int sel, input int exp_period);
      int cnt;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (sigOf(sel)) begin ok = 1'b1; break; end
      end
      checkOutput({name, "_fs_x"}, 32'(sel == 2 ? a_x : b_x), 32'd0);
      checkOutput({name, "_fs_y"}, 32'(sel == 2 ? a_y : b_y), 32'd0);
      cnt = 0;
      for (int i = 0; ok && i < 4000; i++) begin
         @(posedge clk); #1;
         cnt++;
         if (sigOf(sel)) break;
      end
      checkOutput({name, "_frame_period"}, 32'(cnt), 32'(exp_period));
   endtask

   task automatic applyStimulus();
      int cnt;
      // Reset held from time 0, released on a falling edge.
      repeat (3) @(negedge clk);
      checkOutput("rst_a_hs", 32'(a_hs), 32'd1);
      checkOutput("rst_b_hs", 32'(b_hs), 32'd0);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         cnt++;
         if (a_x == 10'd1) break;
      end
      checkOutput("first_advance_clks", 32'(cnt), 32'd5);
      checkOutput("first_advance_pix_en", 32'(a_pe), 32'd1);

      measurePulse("a_hs", 0, 1'b0, HSW * 4, HT * 4);
      measurePulse("b_hs", 1, 1'b1, HSW, HT);
      measureFrame("a", 2, HT * VT * 4);
      measureFrame("b", 3, HT * VT);

      // Async reset mid-frame: outputs must clear without a clock edge.
      cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (a_x == 10'd30 && a_y == 10'd10) break;
         cnt++;
      end
      checkOutput("reach_30_10", 32'(cnt < 4000), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_a_x", 32'(a_x), 32'd0);
      checkOutput("async_a_y", 32'(a_y), 32'd0);
      checkOutput("async_a_hs", 32'(a_hs), 32'd1);
      checkOutput("async_a_vs", 32'(a_vs), 32'd1);
      checkOutput("async_b_vs", 32'(b_vs), 32'd0);
      checkOutput("async_a_blank", 32'(a_blank), 32'd0);
      checkOutput("async_b_pix_en", 32'(b_pe), 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         cnt++;
         if (a_fs) break;
      end
      checkOutput("restart_first_fs_clks", 32'(cnt), 32'(HT * VT * 4 + 1));

      // Random run lengths and asynchronous reset pulses, some shorter than a clock.
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(50, 3000)) @(posedge clk);
         #($urandom_range(1, 4)) rst = 1'b1;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #($urandom_range(1, 4)) rst = 1'b0;
      end
      repeat (3200) @(posedge clk);
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cmp_on = 1'b1;
      applyStimulus();
      @(negedge clk);
      cmp_on = 1'b0;
      checkOutput("a_y_max", 32'(max_ay), 32'(VT - 1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
